// File: rtl/data_bus_decoder_pkg.sv
// Shared types and default memory-map constants for the CPU data bus decoder
// and any other master that reuses its address map.
package data_bus_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP,
      ST_GAP
   } state_t;

   localparam logic [19:0] BIOS_BASE_DEFAULT  = 20'hFC000;
   localparam int unsigned BIOS_WORDS_DEFAULT = 8192;
   localparam logic [19:0] RAM_TOP_DEFAULT    = 20'hA0000;
   localparam logic [15:0] ERROR_DATA         = 16'hFFFF;

endpackage

// File: rtl/data_bus_addr_map.sv
// Combinational decode of a 19-bit word address into a one-hot device target.
// BIOS takes priority so the hit outputs stay one-hot even if windows overlap.
module data_bus_addr_map
   import data_bus_decoder_pkg::*;
#(
   parameter logic [19:0] bios_base  = BIOS_BASE_DEFAULT,
   parameter int unsigned bios_words = BIOS_WORDS_DEFAULT,
   parameter logic [19:0] ram_top    = RAM_TOP_DEFAULT
) (
   input  logic [18:0] addr,
   output logic        bios_hit,
   output logic        ram_hit
);

   // 21-bit compare so a BIOS window ending at 1 MiB does not wrap to 0
   localparam logic [20:0] BIOS_LO = {1'b0, bios_base};
   localparam logic [20:0] BIOS_HI = BIOS_LO + 21'(2 * bios_words);
   localparam logic [20:0] RAM_HI  = {1'b0, ram_top};

   logic [20:0] byte_addr;

   always_comb begin
      byte_addr = {1'b0, addr, 1'b0};
      bios_hit  = (byte_addr >= BIOS_LO) && (byte_addr < BIOS_HI);
      ram_hit   = !bios_hit && (byte_addr < RAM_HI);
   end

endmodule

// File: rtl/data_bus_decoder.sv
// CPU data-port decoder: registers each request, selects BIOS or RAM, waits for
// the device ack (or a timeout) and returns data with a one-cycle ack.
module data_bus_decoder
   import data_bus_decoder_pkg::*;
#(
   parameter logic [19:0] bios_base  = BIOS_BASE_DEFAULT,
   parameter int unsigned bios_words = BIOS_WORDS_DEFAULT,
   parameter logic [19:0] ram_top    = RAM_TOP_DEFAULT,
   parameter int unsigned timeout    = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        data_m_access,
   input  logic [18:0] data_m_addr,
   input  logic [15:0] data_m_data_in,
   input  logic [1:0]  data_m_bytesel,
   input  logic        data_m_wr_en,
   output logic        data_m_ack,
   output logic [15:0] data_m_data_out,
   output logic        dev_access,
   output logic [18:0] dev_addr,
   output logic [15:0] dev_data,
   output logic [1:0]  dev_bytesel,
   output logic        dev_wr_en,
   output logic        bios_cs,
   output logic        ram_cs,
   input  logic        bios_ack,
   input  logic [15:0] bios_data,
   input  logic        ram_ack,
   input  logic [15:0] ram_data,
   output logic        bus_error
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(timeout);

   state_t      state_q, state_d;
   logic [18:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [1:0]  bsel_q, bsel_d;
   logic        wr_q, wr_d;
   logic        sel_bios_q, sel_bios_d;
   logic        sel_ram_q, sel_ram_d;
   logic [15:0] rdata_q, rdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        bios_hit, ram_hit;
   logic        sel_ack;
   logic [15:0] sel_data;

   data_bus_addr_map #(
      .bios_base  (bios_base),
      .bios_words (bios_words),
      .ram_top    (ram_top)
   ) u_addr_map (
      .addr     (data_m_addr),
      .bios_hit (bios_hit),
      .ram_hit  (ram_hit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         bsel_q     <= '0;
         wr_q       <= 1'b0;
         sel_bios_q <= 1'b0;
         sel_ram_q  <= 1'b0;
         rdata_q    <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         bsel_q     <= bsel_d;
         wr_q       <= wr_d;
         sel_bios_q <= sel_bios_d;
         sel_ram_q  <= sel_ram_d;
         rdata_q    <= rdata_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      bsel_d     = bsel_q;
      wr_d       = wr_q;
      sel_bios_d = sel_bios_q;
      sel_ram_d  = sel_ram_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      // only the selected device may complete the transfer
      sel_ack    = (sel_bios_q & bios_ack) | (sel_ram_q & ram_ack);
      sel_data   = sel_bios_q ? bios_data : ram_data;

      unique case (state_q)
         ST_IDLE: begin
            if (data_m_access) begin
               addr_d     = data_m_addr;
               wdata_d    = data_m_data_in;
               bsel_d     = data_m_bytesel;
               wr_d       = data_m_wr_en;
               sel_bios_d = bios_hit;
               sel_ram_d  = ram_hit;
               cnt_d      = '0;
               if (bios_hit || ram_hit) begin
                  state_d = ST_WAIT;
               end else begin
                  rdata_d = ERROR_DATA;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (sel_ack) begin
               rdata_d = wr_q ? '0 : sel_data;
               state_d = ST_RESP;
            end else if (cnt_d == TIMEOUT_CNT) begin
               rdata_d = ERROR_DATA;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_GAP;
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign dev_access      = (state_q == ST_WAIT);
   assign bios_cs         = dev_access & sel_bios_q;
   assign ram_cs          = dev_access & sel_ram_q;
   assign dev_addr        = addr_q;
   assign dev_data        = wdata_q;
   assign dev_bytesel     = bsel_q;
   assign dev_wr_en       = wr_q;
   assign data_m_ack      = (state_q == ST_RESP);
   assign data_m_data_out = data_m_ack ? rdata_q : '0;
   assign bus_error       = err_q;

endmodule
